// File: rtl/dbus_mmio_router_pkg.sv
// Shared definitions for the CPU data-bus router and the data-memory controller:
// region enum, region base codes (address bits [31:20]), memop codes, decode helper.
package dbus_mmio_router_pkg;

  typedef enum logic [2:0] {
    REG_NONE  = 3'd0,
    REG_DMEM  = 3'd1,
    REG_VMEM  = 3'd2,
    REG_KBD   = 3'd3,
    REG_TIMER = 3'd4,
    REG_LED   = 3'd5
  } region_e;

  localparam logic [11:0] BASE_DMEM  = 12'h001;
  localparam logic [11:0] BASE_VMEM  = 12'h002;
  localparam logic [11:0] BASE_KBD   = 12'h003;
  localparam logic [11:0] BASE_TIMER = 12'h004;
  localparam logic [11:0] BASE_LED   = 12'h005;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  function automatic region_e decode_region(input logic [31:0] addr);
    case (addr[31:20])
      BASE_DMEM:  decode_region = REG_DMEM;
      BASE_VMEM:  decode_region = REG_VMEM;
      BASE_KBD:   decode_region = REG_KBD;
      BASE_TIMER: decode_region = REG_TIMER;
      BASE_LED:   decode_region = REG_LED;
      default:    decode_region = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dbus_mmio_router_mmio_timer.sv
// Millisecond timer: prescaler counts 0..CLK_HZ/1000-1, timer_ms increments on wrap.
// Ports: clk, rst (sync, active high), i_clr (clears both counters, wins over
// increment), o_ms (32-bit millisecond count, wraps naturally).
module mmio_timer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  output logic [31:0] o_ms
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] r_pre;
  logic [31:0]   r_ms;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_ms  <= r_ms + 32'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign o_ms = r_ms;

endmodule

// File: rtl/dbus_mmio_router.sv
// CPU data-bus router: decodes load/store addresses into DMEM / VMEM / KBD /
// TIMER / LED regions, drives the per-region strobes, owns the LED register,
// timer and keyboard pop, and returns one load word the cycle after cpu_re.
// Ports: cpu_* (CPU side), dmem_* (data-memory controller, 1-cycle read
// latency), vmem_* (text video memory), kbd_* (keyboard FIFO), led (LED reg).
module dbus_mmio_router
  import dbus_mmio_router_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int VMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cpu_addr,
  input  logic [2:0]         cpu_memop,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic [31:0]        dmem_addr,
  output logic [2:0]         dmem_memop,
  output logic [31:0]        dmem_datain,
  output logic               dmem_we,
  input  logic [31:0]        dmem_dataout,
  output logic               vmem_we,
  output logic [VMEM_AW-1:0] vmem_addr,
  output logic [7:0]         vmem_wdata,
  input  logic               kbd_valid,
  input  logic [7:0]         kbd_data,
  output logic               kbd_pop,
  output logic [15:0]        led
);

  region_e     w_region;
  logic [31:0] w_ms;
  logic [31:0] w_imm_rdata;
  logic        w_tmr_clr;

  region_e     r_rd_region;
  logic        r_rd_pend;
  logic [31:0] r_rd_hold;
  logic [15:0] r_led;

  assign w_region = decode_region(cpu_addr);

  assign dmem_addr   = cpu_addr;
  assign dmem_memop  = cpu_memop;
  assign dmem_datain = cpu_wdata;
  assign dmem_we     = cpu_we & ~rst & (w_region == REG_DMEM);
  assign vmem_we     = cpu_we & ~rst & (w_region == REG_VMEM);
  assign vmem_addr   = cpu_addr[VMEM_AW-1:0];
  assign vmem_wdata  = cpu_wdata[7:0];
  assign kbd_pop     = cpu_re & ~rst & (w_region == REG_KBD) & kbd_valid;
  assign w_tmr_clr   = cpu_we & (w_region == REG_TIMER);
  assign led         = r_led;

  mmio_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .o_ms  (w_ms)
  );

  // Register-backed regions are sampled at the load edge, so a same-cycle
  // store still returns the pre-store value.
  always_comb begin
    w_imm_rdata = 32'h0;
    case (w_region)
      REG_KBD:   w_imm_rdata = {24'h0, kbd_valid ? kbd_data : 8'h0};
      REG_TIMER: w_imm_rdata = w_ms;
      REG_LED:   w_imm_rdata = {16'h0, r_led};
      default:   w_imm_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= 16'h0;
    end else if (cpu_we && w_region == REG_LED) begin
      r_led <= cpu_wdata[15:0];
    end
  end

  // DMEM data shows up one cycle after the load; pass it through that cycle
  // and latch it so cpu_rdata keeps holding until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_rd_region <= REG_NONE;
      r_rd_hold   <= 32'h0;
    end else begin
      r_rd_pend <= cpu_re;
      if (cpu_re) begin
        r_rd_region <= w_region;
        r_rd_hold   <= w_imm_rdata;
      end else if (r_rd_pend && r_rd_region == REG_DMEM) begin
        r_rd_hold <= dmem_dataout;
      end
    end
  end

  assign cpu_rdata = (r_rd_pend && r_rd_region == REG_DMEM) ? dmem_dataout : r_rd_hold;

endmodule

// File: tb/tb_dbus_mmio_router.sv
module tb_dbus_mmio_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [2:0]  cpu_memop;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [31:0] dmem_addr, dmem_datain, dmem_dataout;
  logic [2:0]  dmem_memop;
  logic        dmem_we, vmem_we, kbd_valid, kbd_pop;
  logic [11:0] vmem_addr;
  logic [7:0]  vmem_wdata, kbd_data;
  logic [15:0] led;

  always #5 clk = ~clk;

  dbus_mmio_router #(.CLK_HZ(4000), .VMEM_AW(12)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_memop(cpu_memop),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dmem_addr(dmem_addr), .dmem_memop(dmem_memop), .dmem_datain(dmem_datain),
    .dmem_we(dmem_we), .dmem_dataout(dmem_dataout), .vmem_we(vmem_we),
    .vmem_addr(vmem_addr), .vmem_wdata(vmem_wdata), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .kbd_pop(kbd_pop), .led(led)
  );

  // Data-memory environment: word array, one-cycle registered read.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    dmem_dataout <= mem[dmem_addr[7:2]];
    if (dmem_we) mem[dmem_addr[7:2]] <= dmem_datain;
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] led_m;
  int unsigned n_m;     // clock edges since the timer was last cleared
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int reg_of(input logic [31:0] a);
    case (a[31:20])
      12'h001: return 1;
      12'h002: return 2;
      12'h003: return 3;
      12'h004: return 4;
      12'h005: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] op = 3'b010);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd; cpu_memop = op;
  endtask

  // One bus cycle: check strobes, advance the model over the edge, check outputs.
  task automatic cyc();
    int          r;
    logic [31:0] nxt;
    bit          ld;
    #1;
    r = reg_of(cpu_addr);
    chk("dmem_we", {31'b0, dmem_we}, {31'b0, cpu_we && !rst && r == 1});
    chk("vmem_we", {31'b0, vmem_we}, {31'b0, cpu_we && !rst && r == 2});
    chk("kbd_pop", {31'b0, kbd_pop}, {31'b0, cpu_re && !rst && r == 3 && kbd_valid});
    chk("dmem_addr", dmem_addr, cpu_addr);
    chk("dmem_din", dmem_datain, cpu_wdata);
    chk("dmem_memop", {29'b0, dmem_memop}, {29'b0, cpu_memop});
    if (cpu_we && !rst && r == 2) begin
      chk("vmem_addr", {20'b0, vmem_addr}, {20'b0, cpu_addr[11:0]});
      chk("vmem_wdata", {24'b0, vmem_wdata}, {24'b0, cpu_wdata[7:0]});
    end
    ld = cpu_re && !rst;
    case (r)
      1:       nxt = mem[cpu_addr[7:2]];
      3:       nxt = kbd_valid ? {24'b0, kbd_data} : 32'h0;
      4:       nxt = n_m / 4;
      5:       nxt = {16'b0, led_m};
      default: nxt = 32'h0;
    endcase
    @(posedge clk);
    if (rst) begin
      led_m = 16'h0; n_m = 0; exp_rd = 32'h0;
    end else begin
      if (cpu_we && r == 5) led_m = cpu_wdata[15:0];
      if (cpu_we && r == 4) n_m = 0; else n_m++;
      if (ld) exp_rd = nxt;
    end
    #1;
    chk("cpu_rdata", cpu_rdata, exp_rd);
    chk("led", {16'b0, led}, {16'b0, led_m});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    led_m = 0; n_m = 0; exp_rd = 0;
    kbd_valid = 0; kbd_data = 0;
    rst = 1;
    drive(1, 1, 32'h0010_0008, 32'hDEAD_BEEF);
    cyc(); cyc();
    rst = 0;
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_led", {16'b0, led}, 32'h0);

    // DMEM store then load
    drive(1, 0, 32'h0010_0004, 32'h1234_5678); cyc();
    drive(0, 1, 32'h0010_0004, 32'h0); cyc();
    chk("lw_dmem", cpu_rdata, 32'h1234_5678);
    drive(0, 0, 32'h0010_0020, 32'h0); cyc();
    chk("lw_dmem_hold", cpu_rdata, 32'h1234_5678);

    // VMEM byte store
    drive(1, 0, 32'h0020_0010, 32'h0000_0041, 3'b000);
    #1;
    chk("vmem_addr_lit", {20'b0, vmem_addr}, 32'h010);
    chk("vmem_wdata_lit", {24'b0, vmem_wdata}, 32'h41);
    #1;
    cyc();

    // keyboard pop / empty
    kbd_valid = 1; kbd_data = 8'h61;
    drive(0, 1, 32'h0030_0000, 32'h0); cyc();
    chk("kbd_read", cpu_rdata, 32'h61);
    kbd_valid = 0;
    cyc();
    chk("kbd_empty", cpu_rdata, 32'h0);
    drive(1, 0, 32'h0030_0000, 32'h5); cyc();

    // timer: clear, 40 cycles, read; clear, read
    drive(1, 0, 32'h0040_0000, 32'h0); cyc();
    drive(0, 0, 32'h0000_0000, 32'h0);
    for (int i = 0; i < 40; i++) cyc();
    drive(0, 1, 32'h0040_0000, 32'h0); cyc();
    chk("timer_10", cpu_rdata, 32'd10);
    drive(1, 0, 32'h0040_0000, 32'h0); cyc();
    drive(0, 1, 32'h0040_0000, 32'h0); cyc();
    chk("timer_clr", cpu_rdata, 32'h0);

    // LED store/load, then reset
    drive(1, 0, 32'h0050_0000, 32'hABCD_1234); cyc();
    chk("led_lit", {16'b0, led}, 32'h1234);
    drive(0, 1, 32'h0050_0000, 32'h0); cyc();
    chk("led_read", cpu_rdata, 32'h0000_1234);
    rst = 1; drive(0, 0, 32'h0, 32'h0); cyc(); rst = 0;
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);

    // unmapped load, simultaneous store+load
    drive(1, 0, 32'h0050_0000, 32'h0000_5555); cyc();
    drive(0, 1, 32'h0070_0000, 32'h0); cyc();
    chk("none_read", cpu_rdata, 32'h0);
    drive(1, 1, 32'h0050_0000, 32'h0000_7777); cyc();
    chk("we_re_old", cpu_rdata, 32'h5555);
    chk("we_re_led", {16'b0, led}, 32'h7777);

    // reset mid-load discards the DMEM return
    drive(0, 1, 32'h0010_0004, 32'h0); cyc();
    rst = 1; drive(0, 0, 32'h0, 32'h0); cyc(); rst = 0;
    chk("rst_midload", cpu_rdata, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [11:0] top;
      case ($urandom_range(0, 7))
        0: top = 12'h001; 1: top = 12'h002; 2: top = 12'h003; 3: top = 12'h004;
        4: top = 12'h005; 5: top = 12'h007; 6: top = 12'h001; default: top = 12'h000;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      kbd_valid = $urandom_range(0, 1) != 0;
      kbd_data  = 8'($urandom);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0,
            {top, 12'h0, 8'($urandom)}, $urandom, 3'($urandom_range(0, 5)));
      cyc();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
